// File: rtl/sram_pri_data_pkg.sv
// Shared helpers and request/response types for the private data bank.
// SRAM_PRI_DATA_OUT_REG_EN (see top) does not affect this package.
package sram_pri_data_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 4;
    localparam int unsigned DEF_DATA_WIDTH = 128;
    localparam int unsigned DEF_NB_LANES   = 16;

    function automatic int unsigned lane_w(input int unsigned data_width,
                                           input int unsigned nb_lanes);
        return data_width / nb_lanes;
    endfunction

    // Counter width able to hold the value depth itself (full FIFO).
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    typedef struct packed {
        logic                      we;
        logic [DEF_NB_LANES-1:0]   be;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/GENERIC_MEM.sv
// Behavioural single-port SRAM cut: active-low CEN, RDWEN=1 reads, bit-granular
// active-high BW. Q updates only on a read access and holds otherwise.
module GENERIC_MEM #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  CLK,
    input  logic                  CEN,
    input  logic                  RDWEN,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] BW,
    output logic [DATA_WIDTH-1:0] Q
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (!RDWEN) begin
                mem[A] <= (mem[A] & ~BW) | (D & BW);
            end else begin
                Q <= mem[A];
            end
        end
    end

endmodule

// File: rtl/sram_pri_data_rsp_fifo.sv
// Flop-based read-response FIFO with occupancy count; pointers wrap at DEPTH
// so non-power-of-two depths work.
module sram_pri_data_rsp_fifo
    import sram_pri_data_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [cnt_w(DEPTH)-1:0]     cnt,
    output logic                        empty,
    output logic                        full
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) storage[wr_ptr] <= wdata;
    end

    assign rdata = storage[rd_ptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

// File: rtl/sram_pri_data_bank.sv
// Handshaked byte-lane SRAM data bank with credit-guarded read-response FIFO.
// Define SRAM_PRI_DATA_OUT_REG_EN to register macro Q (read latency 2).
module sram_pri_data_bank
    import sram_pri_data_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DATA_WIDTH     = 128,
    parameter int unsigned NB_LANES       = 16,
    parameter int unsigned RSP_FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [NB_LANES-1:0]   req_be_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  busy_o
);

    localparam int unsigned LANE_W = lane_w(DATA_WIDTH, NB_LANES);
    localparam int unsigned CW     = cnt_w(RSP_FIFO_DEPTH);

    logic                  req_fire;
    logic                  rd_fire;
    logic                  mem_cen;
    logic                  mem_rdwen;
    logic [DATA_WIDTH-1:0] mem_bw;
    logic [DATA_WIDTH-1:0] mem_q;

    logic                  inflight;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic [CW:0]           occupancy;
    logic [CW:0]           credit;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [CW-1:0]         fifo_cnt;
    logic [DATA_WIDTH-1:0] fifo_rdata;

    assign req_fire  = req_valid_i & req_ready_o;
    assign rd_fire   = req_fire & ~req_we_i;
    assign mem_cen   = ~req_fire;
    assign mem_rdwen = ~req_we_i;

    always_comb begin
        mem_bw = '0;
        for (int unsigned l = 0; l < NB_LANES; l++) begin
            mem_bw[l*LANE_W +: LANE_W] = {LANE_W{req_be_i[l]}};
        end
    end

    GENERIC_MEM #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .CLK   (clk_i),
        .CEN   (mem_cen),
        .RDWEN (mem_rdwen),
        .A     (req_addr_i),
        .D     (req_wdata_i),
        .BW    (mem_bw),
        .Q     (mem_q)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_fire;
        end
    end

`ifdef SRAM_PRI_DATA_OUT_REG_EN
    logic                  q_reg_valid;
    logic [DATA_WIDTH-1:0] q_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_reg_valid <= 1'b0;
        end else begin
            q_reg_valid <= inflight;
        end
    end

    always_ff @(posedge clk_i) begin
        if (inflight) q_reg <= mem_q;
    end

    assign src_valid = q_reg_valid;
    assign src_data  = q_reg;
    assign occupancy = {1'b0, fifo_cnt} + (CW+1)'(inflight) + (CW+1)'(q_reg_valid);
    assign busy_o    = inflight | q_reg_valid | ~fifo_empty;
`else
    assign src_valid = inflight;
    assign src_data  = mem_q;
    assign occupancy = {1'b0, fifo_cnt} + (CW+1)'(inflight);
    assign busy_o    = inflight | ~fifo_empty;
`endif

    // Every read in the pipe owns a FIFO slot, so the FIFO can never overflow
    // even if the consumer stalls for the whole read latency.
    assign credit      = (CW+1)'(RSP_FIFO_DEPTH) - occupancy;
    assign req_ready_o = req_we_i | (credit != '0);

    assign fifo_push = src_valid & (~fifo_empty | ~rsp_ready_i);
    assign fifo_pop  = ~fifo_empty & rsp_ready_i;

    sram_pri_data_rsp_fifo #(
        .DEPTH      (RSP_FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (src_data),
        .rdata (fifo_rdata),
        .cnt   (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rsp_valid_o = ~fifo_empty | src_valid;
    assign rsp_rdata_o = !fifo_empty ? fifo_rdata :
                         src_valid   ? src_data   : '0;

    a_src_not_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(src_valid && fifo_full));

endmodule

// File: tb/tb_sram_pri_data_bank.sv
// Scoreboard bench for sram_pri_data_bank: array memory model, queue of expected
// read data, monitor checks data, order, latency, credit, busy and stability.
module tb_sram_pri_data_bank;
    import sram_pri_data_pkg::*;

`ifdef SRAM_PRI_DATA_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [15:0]  req_be;
    logic [3:0]   req_addr;
    logic [127:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_rdata;
    logic         busy;

    sram_pri_data_bank #(
        .ADDR_WIDTH     (4),
        .DATA_WIDTH     (128),
        .NB_LANES       (16),
        .RSP_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_be_i    (req_be),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        int unsigned  cyc;
    } exp_t;

    logic [127:0] model [16];
    exp_t         exp_q [$];
    int unsigned  cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           strict_lat = 0;
    bit           hold = 0;
    logic [127:0] hold_data;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: outstanding reads = entries in exp_q, which defines busy and read credit.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold = 0;
        end else begin
            exp_t e;
            chk("busy", busy, exp_q.size() != 0);
            if (!req_we) chk("rd_ready_credit", req_ready, exp_q.size() < DEPTH);
            else         chk("wr_ready", req_ready, 1);
            if (rsp_valid && rsp_ready) begin
                chk("rsp_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_data", rsp_rdata, e.data);
                    if (strict_lat) chk("rsp_latency", cyc - e.cyc, LAT);
                end
            end
            if (rsp_valid && !rsp_ready) begin
                if (hold) chk("rsp_stable", rsp_rdata, hold_data);
                hold = 1;
                hold_data = rsp_rdata;
            end else begin
                hold = 0;
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    for (int l = 0; l < 16; l++)
                        if (req_be[l]) model[req_addr][l*8 +: 8] = req_wdata[l*8 +: 8];
                end else begin
                    e.data = model[req_addr];
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [15:0] be, input logic [3:0] addr,
                         input logic [127:0] wd, output int stalls);
        req_valid = 1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            stalls++;
            if (stalls > 200) begin
                chk("issue_timeout", req_ready, 1);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic drain();
        int t;
        rsp_ready = 1;
        req_valid = 0;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", exp_q.size() != 0 || busy, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int st;
        int acc;
        logic [3:0] bpa [4];
        req_t r;

        rst_n = 0; req_valid = 0; req_we = 0; req_be = '0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rsp_rdata, '0);
        @(posedge clk); #1;
        rst_n = 1;

        for (int a = 0; a < 16; a++) issue(1, '1, 4'(a), rand128(), st);

        // Reset mid-read: the accepted read must vanish.
        issue(0, '0, 4'd1, '0, st);
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_valid", rsp_valid, 0);
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_rsp", rsp_valid, 0);
        end
        @(posedge clk); #1;

        // Lane write.
        issue(1, '1, 4'd3, '1, st);
        issue(1, 16'h0001, 4'd3, 128'h00AA, st);
        issue(0, '0, 4'd3, '0, st);
        repeat (LAT - 1) @(posedge clk);
        @(negedge clk);
        chk("lane_rsp_valid", rsp_valid, 1);
        chk("lane_rdata", rsp_rdata, {{15{8'hFF}}, 8'hAA});
        drain();

        // Read-then-write and write-then-read on the same address.
        issue(0, '0, 4'd7, '0, st);
        issue(1, '1, 4'd7, rand128(), st);
        issue(0, '0, 4'd7, '0, st);
        drain();

        // Streaming.
        strict_lat = 1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            issue(0, '0, 4'($urandom_range(0, 15)), '0, st);
            acc += st;
        end
`ifndef SRAM_PRI_DATA_OUT_REG_EN
        chk("stream_stalls", acc, 0);
`endif
        drain();
        strict_lat = 0;

        // Backpressure, then a write while the FIFO is full.
        for (int i = 0; i < 4; i++) bpa[i] = 4'($urandom_range(0, 15));
        rsp_ready = 0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = (acc < 4); req_we = 0; req_addr = bpa[acc % 4];
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            @(posedge clk); #1;
        end
        chk("bp_accepts", acc, DEPTH);
        @(negedge clk);
        chk("bp_rd_blocked", req_ready, 0);
        @(posedge clk); #1;
        req_we = 1; req_addr = 4'd5; req_be = 16'($urandom); req_wdata = rand128();
        @(negedge clk);
        chk("wr_under_stall_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0; req_we = 0;
        repeat (3) @(posedge clk);
        #1;
        drain();
        issue(0, '0, 4'd5, '0, st);
        drain();

        // Push and pop in the same cycle with one entry held.
        rsp_ready = 0;
        issue(0, '0, 4'd2, '0, st);
        issue(0, '0, 4'd9, '0, st);
        rsp_ready = 1;
`ifndef SRAM_PRI_DATA_OUT_REG_EN
        @(posedge clk); #1;
        chk("pushpop_cnt", 128'(dut.u_rsp_fifo.cnt), 1);
`endif
        drain();

        // Random traffic with random backpressure; exercises pointer wrap.
        for (int c = 0; c < 400; c++) begin
            r.we    = ($urandom_range(0, 99) < 40);
            r.be    = 16'($urandom);
            r.addr  = 4'($urandom);
            r.wdata = rand128();
            req_valid = ($urandom_range(0, 99) < 70);
            req_we = r.we; req_be = r.be; req_addr = r.addr; req_wdata = r.wdata;
            rsp_ready = ($urandom_range(0, 99) < 60);
            @(posedge clk); #1;
        end
        drain();
        chk("all_responses", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
